// File: rtl/vai_pkg.sv
// Shared VAI types: CCI-P Tx port structs, cache-line address/mdata widths, audit error flags.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package vai_pkg;

   localparam int VAI_CLADDR_WIDTH = 42;
   localparam int VAI_MDATA_WIDTH  = 16;

   typedef logic [VAI_CLADDR_WIDTH-1:0] t_vai_claddr;
   typedef logic [VAI_MDATA_WIDTH-1:0]  t_vai_mdata;

   typedef enum logic [3:0] {
      eREQ_RDLINE_I = 4'h0,
      eREQ_RDLINE_S = 4'h1
   } t_ccip_c0_req;

   typedef enum logic [3:0] {
      eREQ_WRLINE_I = 4'h0,
      eREQ_WRLINE_M = 4'h1,
      eREQ_WRPUSH_I = 4'h2,
      eREQ_WRFENCE  = 4'h4
   } t_ccip_c1_req;

   typedef struct packed {
      logic [1:0]   vc_sel;
      logic [1:0]   cl_len;
      t_ccip_c0_req req_type;
      logic [5:0]   rsvd0;
      t_vai_claddr  address;
      t_vai_mdata   mdata;
   } t_ccip_c0_ReqMemHdr;

   typedef struct packed {
      logic [1:0]   vc_sel;
      logic         sop;
      logic [1:0]   cl_len;
      t_ccip_c1_req req_type;
      logic [5:0]   rsvd0;
      t_vai_claddr  address;
      t_vai_mdata   mdata;
   } t_ccip_c1_ReqMemHdr;

   typedef struct packed {
      logic [8:0] tid;
   } t_ccip_c2_RspMmioHdr;

   typedef struct packed {
      t_ccip_c0_ReqMemHdr hdr;
      logic               valid;
   } t_if_ccip_c0_Tx;

   typedef struct packed {
      t_ccip_c1_ReqMemHdr hdr;
      logic [511:0]       data;
      logic               valid;
   } t_if_ccip_c1_Tx;

   typedef struct packed {
      t_ccip_c2_RspMmioHdr hdr;
      logic                mmioRdValid;
      logic [63:0]         data;
   } t_if_ccip_c2_Tx;

   typedef struct packed {
      t_if_ccip_c0_Tx c0;
      t_if_ccip_c1_Tx c1;
      t_if_ccip_c2_Tx c2;
   } t_if_ccip_Tx;

   typedef struct packed {
      logic ovf;
      logic cfg;
   } t_vai_audit_err;

   // Replace the top 'width' bits of mdata with the VM index so Rx responses can be demuxed.
   function automatic t_vai_mdata vai_tag_mdata(input t_vai_mdata mdata,
                                                input t_vai_mdata vmid,
                                                input int         width);
      t_vai_mdata mask;
      mask = ~(16'hFFFF >> width);
      return (mdata & ~mask) | ((vmid << (VAI_MDATA_WIDTH - width)) & mask);
   endfunction

endpackage

// File: rtl/vai_addr_xlate.sv
// Relocates one cache-line address by the per-VM offset and decides drop (overflow / bad offset).
// Latency: 1 cycle, all outputs registered.
// Backpressure: none; a valid input always produces a registered result next cycle.
module vai_addr_xlate
   import vai_pkg::*;
(
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_vld,
   input  logic           i_bypass,
   input  t_vai_claddr    i_addr,
   input  logic [63:0]    i_offset,
   output logic           o_vld,
   output t_vai_claddr    o_addr,
   output t_vai_audit_err o_err
);

   logic [VAI_CLADDR_WIDTH:0] w_sum;
   logic                      w_ovf;
   logic                      w_cfg;

   // 43-bit add; the carry out is the overflow indication. Fences skip translation and the check.
   always_comb begin
      w_sum = {1'b0, i_addr} + {1'b0, i_offset[VAI_CLADDR_WIDTH-1:0]};
      w_ovf = i_vld & ~i_bypass & w_sum[VAI_CLADDR_WIDTH];
      w_cfg = i_vld & (|i_offset[63:VAI_CLADDR_WIDTH]);
   end

   // Register the translated address, surviving valid and per-request error pulses.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_vld  <= 1'b0;
         o_addr <= '0;
         o_err  <= '0;
      end else begin
         o_vld     <= i_vld & ~w_ovf & ~w_cfg;
         o_addr    <= i_bypass ? i_addr : w_sum[VAI_CLADDR_WIDTH-1:0];
         o_err.ovf <= w_ovf;
         o_err.cfg <= w_cfg;
      end
   end

endmodule

// File: rtl/vai_tx_auditor.sv
// Per-VM CCI-P Tx guard: relocates c0/c1 addresses, tags mdata with VMID, drops bad requests.
// Latency: fixed 2 cycles on every channel (T1 capture, T2 translate/register).
// Backpressure: none; no buffering, flow control is owned upstream. Optional: VAI_AUDIT_STATS_EN.
module vai_tx_auditor
   import vai_pkg::*;
#(
   parameter int NUM_SUB_AFUS = 8,
   parameter int VMID         = 0,
   parameter int VMID_WIDTH   = $clog2(NUM_SUB_AFUS)
) (
   input  logic        clk,
   input  logic        resetb,
   input  logic        sub_reset,
   input  logic [63:0] offset,
   input  t_if_ccip_Tx afu_TxPort,
   output t_if_ccip_Tx mux_TxPort,
   output logic        err_addr_ovf,
   output logic        err_cfg
`ifdef VAI_AUDIT_STATS_EN
   ,
   output logic [31:0] c0_req_cnt,
   output logic [31:0] c1_req_cnt,
   output logic [15:0] drop_cnt
`endif
);

   logic [1:0]         r_rst_sync;
   logic               w_rst_n;
   t_if_ccip_Tx        w_t1_in;
   t_if_ccip_Tx        r_t1_tx;
   logic [63:0]        r_t1_offset;
   logic               w_c0_vld;
   logic               w_c1_vld;
   logic               w_c1_fence;
   t_ccip_c0_ReqMemHdr w_c0_hdr_tag;
   t_ccip_c1_ReqMemHdr w_c1_hdr_tag;
   t_ccip_c0_ReqMemHdr r_t2_c0_hdr;
   t_ccip_c1_ReqMemHdr r_t2_c1_hdr;
   logic [511:0]       r_t2_c1_data;
   t_if_ccip_c2_Tx     r_t2_c2;
   logic               w_c0_vld_out;
   logic               w_c1_vld_out;
   t_vai_claddr        w_c0_addr;
   t_vai_claddr        w_c1_addr;
   t_vai_audit_err     w_err_c0;
   t_vai_audit_err     w_err_c1;
   logic               r_err_ovf;
   logic               r_err_cfg;

   // Reset asserts asynchronously, deassertion is aligned to clk through two flops.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) r_rst_sync <= 2'b00;
      else         r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   // Soft reset blocks c0/c1 requests from entering T1; c2 is never gated.
   always_comb begin
      w_t1_in          = afu_TxPort;
      w_t1_in.c0.valid = afu_TxPort.c0.valid & ~sub_reset;
      w_t1_in.c1.valid = afu_TxPort.c1.valid & ~sub_reset;
   end

   // T1: capture the Tx port together with the offset so each request uses its own offset.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_t1_tx     <= '0;
         r_t1_offset <= '0;
      end else begin
         r_t1_tx     <= w_t1_in;
         r_t1_offset <= offset;
      end
   end

   // Entries already in T1 are also discarded while soft reset is held.
   always_comb begin
      w_c0_vld     = r_t1_tx.c0.valid & ~sub_reset;
      w_c1_vld     = r_t1_tx.c1.valid & ~sub_reset;
      w_c1_fence   = (r_t1_tx.c1.hdr.req_type == eREQ_WRFENCE);
      w_c0_hdr_tag = r_t1_tx.c0.hdr;
      w_c1_hdr_tag = r_t1_tx.c1.hdr;
      w_c0_hdr_tag.mdata = vai_tag_mdata(r_t1_tx.c0.hdr.mdata, VAI_MDATA_WIDTH'(VMID), VMID_WIDTH);
      w_c1_hdr_tag.mdata = vai_tag_mdata(r_t1_tx.c1.hdr.mdata, VAI_MDATA_WIDTH'(VMID), VMID_WIDTH);
   end

   vai_addr_xlate u_xlate_c0 (
      .i_clk    (clk),
      .i_rst_n  (w_rst_n),
      .i_vld    (w_c0_vld),
      .i_bypass (1'b0),
      .i_addr   (r_t1_tx.c0.hdr.address),
      .i_offset (r_t1_offset),
      .o_vld    (w_c0_vld_out),
      .o_addr   (w_c0_addr),
      .o_err    (w_err_c0)
   );

   vai_addr_xlate u_xlate_c1 (
      .i_clk    (clk),
      .i_rst_n  (w_rst_n),
      .i_vld    (w_c1_vld),
      .i_bypass (w_c1_fence),
      .i_addr   (r_t1_tx.c1.hdr.address),
      .i_offset (r_t1_offset),
      .o_vld    (w_c1_vld_out),
      .o_addr   (w_c1_addr),
      .o_err    (w_err_c1)
   );

   // T2: register the tagged headers, write data and the c2 response alongside the translation.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_t2_c0_hdr  <= '0;
         r_t2_c1_hdr  <= '0;
         r_t2_c1_data <= '0;
         r_t2_c2      <= '0;
      end else begin
         r_t2_c0_hdr  <= w_c0_hdr_tag;
         r_t2_c1_hdr  <= w_c1_hdr_tag;
         r_t2_c1_data <= r_t1_tx.c1.data;
         r_t2_c2      <= r_t1_tx.c2;
      end
   end

   // Merge the registered translated address and valid into the outgoing headers.
   always_comb begin
      mux_TxPort                = '0;
      mux_TxPort.c0.hdr         = r_t2_c0_hdr;
      mux_TxPort.c0.hdr.address = w_c0_addr;
      mux_TxPort.c0.valid       = w_c0_vld_out;
      mux_TxPort.c1.hdr         = r_t2_c1_hdr;
      mux_TxPort.c1.hdr.address = w_c1_addr;
      mux_TxPort.c1.data        = r_t2_c1_data;
      mux_TxPort.c1.valid       = w_c1_vld_out;
      mux_TxPort.c2             = r_t2_c2;
   end

   // Sticky error flags; only the hard reset clears them.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_err_ovf <= 1'b0;
         r_err_cfg <= 1'b0;
      end else begin
         r_err_ovf <= r_err_ovf | w_err_c0.ovf | w_err_c1.ovf;
         r_err_cfg <= r_err_cfg | w_err_c0.cfg | w_err_c1.cfg;
      end
   end

   // Flags rise in the same cycle the dropped request would have left T2.
   assign err_addr_ovf = r_err_ovf | w_err_c0.ovf | w_err_c1.ovf;
   assign err_cfg      = r_err_cfg | w_err_c0.cfg | w_err_c1.cfg;

`ifdef VAI_AUDIT_STATS_EN
   logic [1:0] w_drop_n;

   always_comb begin
      w_drop_n = {1'b0, (w_err_c0.ovf | w_err_c0.cfg)} + {1'b0, (w_err_c1.ovf | w_err_c1.cfg)};
   end

   // Issue and drop counters, wrapping, cleared by either reset.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         c0_req_cnt <= '0;
         c1_req_cnt <= '0;
         drop_cnt   <= '0;
      end else if (sub_reset) begin
         c0_req_cnt <= '0;
         c1_req_cnt <= '0;
         drop_cnt   <= '0;
      end else begin
         c0_req_cnt <= c0_req_cnt + 32'(w_c0_vld_out);
         c1_req_cnt <= c1_req_cnt + 32'(w_c1_vld_out);
         drop_cnt   <= drop_cnt + 16'(w_drop_n);
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_vai_tx_auditor.sv
// Directed bench for vai_tx_auditor with VMID 3 of 8 (3-bit mdata tag, tag value 3'b011).
// Latency: expects every channel 2 cycles after the driving edge.
// Backpressure: none exercised; the DUT has no backpressure path.
module tb_vai_tx_auditor;
   import vai_pkg::*;

   logic        clk = 1'b0;
   logic        resetb;
   logic        sub_reset;
   logic [63:0] offset;
   t_if_ccip_Tx afu_tx;
   t_if_ccip_Tx mux_tx;
   logic        err_addr_ovf;
   logic        err_cfg;
   int          checks = 0;
   int          errors = 0;
   logic [511:0] wdata;

`ifdef VAI_AUDIT_STATS_EN
   logic [31:0] c0_req_cnt;
   logic [31:0] c1_req_cnt;
   logic [15:0] drop_cnt;
`endif

   always #5 clk = ~clk;

   vai_tx_auditor #(.NUM_SUB_AFUS(8), .VMID(3)) dut (
      .clk          (clk),
      .resetb       (resetb),
      .sub_reset    (sub_reset),
      .offset       (offset),
      .afu_TxPort   (afu_tx),
      .mux_TxPort   (mux_tx),
      .err_addr_ovf (err_addr_ovf),
      .err_cfg      (err_cfg)
`ifdef VAI_AUDIT_STATS_EN
      ,
      .c0_req_cnt   (c0_req_cnt),
      .c1_req_cnt   (c1_req_cnt),
      .drop_cnt     (drop_cnt)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      wdata = {8{64'hA5A5_0000_1111_2222}};
      afu_tx    = '0;
      sub_reset = 1'b0;
      offset    = '0;
      resetb    = 1'b0;
      #3;
      chk("rst_c0_vld", 64'(mux_tx.c0.valid), 64'd0);
      chk("rst_c1_vld", 64'(mux_tx.c1.valid), 64'd0);
      chk("rst_c2_vld", 64'(mux_tx.c2.mmioRdValid), 64'd0);
      chk("rst_c0_addr", 64'(mux_tx.c0.hdr.address), 64'd0);
      chk("rst_ovf", 64'(err_addr_ovf), 64'd0);
      chk("rst_cfg", 64'(err_cfg), 64'd0);
      tick(); tick();
      resetb = 1'b1;
      tick(); tick(); tick();

      // Basic c0 relocation and tagging.
      offset = 64'h100;
      afu_tx.c0.valid       = 1'b1;
      afu_tx.c0.hdr.req_type = eREQ_RDLINE_I;
      afu_tx.c0.hdr.address = 42'h20;
      afu_tx.c0.hdr.mdata   = 16'h0005;
      tick();
      afu_tx = '0;
      chk("c0_lat1_vld", 64'(mux_tx.c0.valid), 64'd0);
      tick();
      chk("c0_vld", 64'(mux_tx.c0.valid), 64'd1);
      chk("c0_addr", 64'(mux_tx.c0.hdr.address), 64'h120);
      chk("c0_mdata", 64'(mux_tx.c0.hdr.mdata), 64'h6005);
      chk("c0_ovf", 64'(err_addr_ovf), 64'd0);
      chk("c0_cfg", 64'(err_cfg), 64'd0);
      tick();
      chk("c0_vld_gone", 64'(mux_tx.c0.valid), 64'd0);

      // c1 overflow drop, then legal c1 write: flag stays set.
      offset = 64'h1;
      afu_tx.c1.valid        = 1'b1;
      afu_tx.c1.hdr.req_type = eREQ_WRLINE_I;
      afu_tx.c1.hdr.address  = 42'h3FF_FFFF_FFFF;
      afu_tx.c1.hdr.mdata    = 16'h0011;
      afu_tx.c1.data         = wdata;
      tick();
      afu_tx = '0;
      tick();
      chk("ovf_c1_vld", 64'(mux_tx.c1.valid), 64'd0);
      chk("ovf_flag", 64'(err_addr_ovf), 64'd1);
      chk("ovf_cfg", 64'(err_cfg), 64'd0);
      offset = 64'h10;
      afu_tx.c1.valid        = 1'b1;
      afu_tx.c1.hdr.req_type = eREQ_WRLINE_M;
      afu_tx.c1.hdr.address  = 42'h100;
      afu_tx.c1.hdr.mdata    = 16'h0022;
      afu_tx.c1.data         = wdata;
      tick();
      afu_tx = '0;
      tick();
      chk("c1_vld", 64'(mux_tx.c1.valid), 64'd1);
      chk("c1_addr", 64'(mux_tx.c1.hdr.address), 64'h110);
      chk("c1_mdata", 64'(mux_tx.c1.hdr.mdata), 64'h6022);
      chk("c1_type", 64'(mux_tx.c1.hdr.req_type), 64'h1);
      chk("c1_data_lo", mux_tx.c1.data[63:0], 64'hA5A5_0000_1111_2222);
      chk("c1_data_hi", mux_tx.c1.data[511:448], 64'hA5A5_0000_1111_2222);
      chk("ovf_sticky", 64'(err_addr_ovf), 64'd1);

      // Offset with bit 42 set: cfg drop; then a good offset passes.
      offset = 64'h0000_0400_0000_0000;
      afu_tx.c0.valid       = 1'b1;
      afu_tx.c0.hdr.address = 42'h20;
      afu_tx.c0.hdr.mdata   = 16'h0001;
      tick();
      offset = 64'h10;
      afu_tx.c0.hdr.address = 42'h30;
      afu_tx.c0.hdr.mdata   = 16'h1234;
      tick();
      afu_tx = '0;
      chk("cfg_c0_vld", 64'(mux_tx.c0.valid), 64'd0);
      chk("cfg_flag", 64'(err_cfg), 64'd1);
      tick();
      chk("cfg_next_vld", 64'(mux_tx.c0.valid), 64'd1);
      chk("cfg_next_addr", 64'(mux_tx.c0.hdr.address), 64'h40);
      chk("cfg_next_mdata", 64'(mux_tx.c0.hdr.mdata), 64'h7234);
      chk("cfg_sticky", 64'(err_cfg), 64'd1);

      // Write fence: no translation, mdata still tagged.
      offset = 64'h500;
      afu_tx.c1.valid        = 1'b1;
      afu_tx.c1.hdr.req_type = eREQ_WRFENCE;
      afu_tx.c1.hdr.address  = 42'hABC;
      afu_tx.c1.hdr.mdata    = 16'h8001;
      tick();
      afu_tx = '0;
      tick();
      chk("fence_vld", 64'(mux_tx.c1.valid), 64'd1);
      chk("fence_addr", 64'(mux_tx.c1.hdr.address), 64'hABC);
      chk("fence_mdata", 64'(mux_tx.c1.hdr.mdata), 64'h6001);

      // Back-to-back c0 with a one-cycle soft reset; c2 issued in that cycle survives.
      offset = 64'h0;
      afu_tx.c0.valid       = 1'b1;
      afu_tx.c0.hdr.mdata   = 16'h0000;
      afu_tx.c0.hdr.address = 42'h1;
      tick();
      afu_tx.c0.hdr.address = 42'h2;
      afu_tx.c2.mmioRdValid = 1'b1;
      afu_tx.c2.hdr.tid     = 9'h055;
      afu_tx.c2.data        = 64'hDEAD_BEEF_0123_4567;
      sub_reset = 1'b1;
      tick();
      chk("srst_a_drop", 64'(mux_tx.c0.valid), 64'd0);
      sub_reset = 1'b0;
      afu_tx.c2 = '0;
      afu_tx.c0.hdr.address = 42'h3;
      tick();
      chk("srst_b_drop", 64'(mux_tx.c0.valid), 64'd0);
      chk("srst_c2_vld", 64'(mux_tx.c2.mmioRdValid), 64'd1);
      chk("srst_c2_tid", 64'(mux_tx.c2.hdr.tid), 64'h055);
      chk("srst_c2_data", mux_tx.c2.data, 64'hDEAD_BEEF_0123_4567);
      afu_tx.c0.hdr.address = 42'h4;
      tick();
      afu_tx = '0;
      chk("srst_c_vld", 64'(mux_tx.c0.valid), 64'd1);
      chk("srst_c_addr", 64'(mux_tx.c0.hdr.address), 64'h3);
      chk("srst_c_mdata", 64'(mux_tx.c0.hdr.mdata), 64'h6000);
      chk("srst_c2_gone", 64'(mux_tx.c2.mmioRdValid), 64'd0);
      tick();
      chk("srst_d_vld", 64'(mux_tx.c0.valid), 64'd1);
      chk("srst_d_addr", 64'(mux_tx.c0.hdr.address), 64'h4);
      chk("srst_flags_kept", {62'd0, err_addr_ovf, err_cfg}, 64'h3);

      // Hard reset mid-burst: asynchronous clear, then clean restart.
      offset = 64'h100;
      afu_tx.c0.valid       = 1'b1;
      afu_tx.c0.hdr.address = 42'h8;
      afu_tx.c1.valid        = 1'b1;
      afu_tx.c1.hdr.req_type = eREQ_WRLINE_I;
      afu_tx.c1.hdr.address  = 42'h9;
      tick(); tick();
      chk("burst_c0_vld", 64'(mux_tx.c0.valid), 64'd1);
      chk("burst_c1_vld", 64'(mux_tx.c1.valid), 64'd1);
      #2 resetb = 1'b0;
      #1;
      chk("arst_c0_vld", 64'(mux_tx.c0.valid), 64'd0);
      chk("arst_c1_vld", 64'(mux_tx.c1.valid), 64'd0);
      chk("arst_flags", {62'd0, err_addr_ovf, err_cfg}, 64'h0);
      afu_tx = '0;
      tick();
      resetb = 1'b1;
      tick(); tick();
      afu_tx.c0.valid       = 1'b1;
      afu_tx.c0.hdr.address = 42'h5;
      afu_tx.c0.hdr.mdata   = 16'h00AA;
      tick();
      afu_tx = '0;
      chk("rel_lat1_vld", 64'(mux_tx.c0.valid), 64'd0);
      tick();
      chk("rel_vld", 64'(mux_tx.c0.valid), 64'd1);
      chk("rel_addr", 64'(mux_tx.c0.hdr.address), 64'h105);
      chk("rel_mdata", 64'(mux_tx.c0.hdr.mdata), 64'h60AA);
      chk("rel_flags", {62'd0, err_addr_ovf, err_cfg}, 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vai_tx_auditor.md
Name: vai_tx_auditor

Overview:
- Per-sub-AFU Tx guard between one sub-AFU's CCI-P Tx port and the VAI mux Tx input; one instance per VMID.
- Relocates c0/c1 cache-line addresses by the manager-programmed per-VM offset and stamps the VMID into the mdata upper bits so Rx responses can be demuxed.
- Drops requests whose relocated address overflows the address space, and flushes traffic while the sub-AFU is held in soft reset.

Parameters:
- NUM_SUB_AFUS, 8, number of sub-AFUs behind the mux.
- VMID, 0, this instance's VM index (0..NUM_SUB_AFUS-1).
- VMID_WIDTH, $clog2(NUM_SUB_AFUS), mdata tag width.

Ports:
- clk  in  1  CCI-P pClk; all logic on its rising edge.
- resetb  in  1  asynchronous, active-low reset.
- sub_reset  in  1  synchronous per-VM soft reset; this VM's bit of sub_afu_reset.
- offset  in  64  per-VM base, in cache-line units; this VM's offset_array entry.
- afu_TxPort  in  t_if_ccip_Tx  Tx from the sub-AFU.
- mux_TxPort  out  t_if_ccip_Tx  audited Tx to the mux.
- err_addr_ovf  out  1  sticky; a c0/c1 request was dropped because of overflow.
- err_cfg  out  1  sticky; offset[63:42] was nonzero when a request arrived.

Behaviour:
- Reset (resetb low, asynchronous): mux_TxPort c0/c1/c2 valids = 0, hdr/data = 0, err_addr_ovf = 0, err_cfg = 0, both pipeline stages invalid. Deassertion is synchronised internally with a 2-flop synchroniser.
- Pipeline: two stages, fixed latency 2 cycles per channel; no backpressure path.
  - T1: register afu_TxPort and offset together. The offset is sampled per request, so a change applies to the next request.
  - T2: translate and check, then register into mux_TxPort.
- c0 (read) / c1 (write):
  - sum = {1'b0, hdr.address[41:0]} + {1'b0, offset[41:0]}, 43-bit.
  - sum[42] = 1 -> drop the request (valid = 0) and set err_addr_ovf.
  - offset[63:42] != 0 -> drop the request and set err_cfg.
  - Otherwise: address = sum[41:0]; mdata[15:16-VMID_WIDTH] = VMID; all other header fields and data unchanged.
- c1 eREQ_WRFENCE: address is not translated and no overflow check applies; mdata is still tagged. err_cfg still applies.
- c2 (MMIO read response): passes through unchanged with 2-cycle latency and is never dropped. It is not gated by sub_reset, so the host MMIO protocol completes.
- sub_reset = 1: c0/c1 valids entering T1 are forced to 0, and valid c0/c1 entries already in T1 are cleared the same cycle. Release takes effect the next cycle. Sticky errors are kept.
- Simultaneous overflow and cfg error on one request: both flags set, one drop.
- Flags clear only on resetb.
- almFull is not handled here; the mux and manager own flow control. The auditor adds no buffering, so in-flight requests number at most 2 per channel.

Optional Feature:
- VAI_AUDIT_STATS_EN
  - Defined: adds outputs c0_req_cnt[31:0], c1_req_cnt[31:0] and drop_cnt[15:0]. Each counts mux_TxPort valid issues and drops respectively, wraps at max, and clears on resetb or sub_reset.
  - Undefined: these ports and their logic are absent.

Decomposition:
- Shared package vai_pkg:
  - VAI_CLADDR_WIDTH = 42, VAI_MDATA_WIDTH = 16.
  - function vai_tag_mdata(mdata, vmid, width).
  - typedef t_vai_audit_err (struct {ovf, cfg}).
- One sub-module, vai_addr_xlate: purely registered 43-bit add plus drop decision, instantiated for c0 and c1.

Test Plan:
- Offset 0x100, VMID 3, c0 read addr 0x20, mdata 0x0005 -> 2 cycles later c0 addr 0x120, mdata 0x6005 (VMID_WIDTH 3), err flags 0.
- Offset 0x1, c1 write addr 0x3FF_FFFF_FFFF -> no c1 valid out, err_addr_ovf = 1 and stays 1 after further legal traffic.
- Offset 0x40_0000_0000_0 (bit 42+ set), c0 read -> dropped, err_cfg = 1; next request after offset 0x10 passes.
- c1 WRFENCE with offset 0x500 -> address field unchanged, mdata tagged, valid out.
- Back-to-back c0 requests, sub_reset pulsed high 1 cycle mid-stream -> requests in T1 and entering T1 that cycle are dropped; a c2 response issued the same cycle still appears 2 cycles later.
- resetb asserted low mid-burst -> all output valids 0 immediately (asynchronously); flags 0; first request after release passes with 2-cycle latency.
